gf_2ton_koa_seq_composer: RTL
=============================

# gf_2toN_koa_seq_composer

Sequential Karatsuba recombination stage that sits directly downstream of the KOA splitter for one instance. It takes the splitter's three half-width operand pairs (low, high, middle), multiplies them one per cycle on a single shared half-width carry-less multiplier, and accumulates the full unreduced GF(2)[x] product. It trades throughput (one product per 4 cycles) for a third of the multiplier area. A valid/ready handshake is used on both sides.

## Interface
Parameters:
- NB_DATA, 128, full operand width; power of 2, at least 8; half width H = NB_DATA/2.

Ports:
- i_clock  in  1  single clock; all logic on rising edge.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_data_bus  in  3*NB_DATA  splitter output.
  - [0 +: NB_DATA] = pair L, [NB_DATA +: NB_DATA] = pair H, [2*NB_DATA +: NB_DATA] = pair M.
  - Within each pair, low H bits = operand X, high H bits = operand Y.
- i_valid  in  1  i_data_bus valid.
- o_ready  out  1  block can accept i_data_bus this cycle.
- o_data  out  2*NB_DATA  unreduced product; bit 2*NB_DATA-1 is always 0.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.

## Operation
- FSM states: IDLE, MUL_L, MUL_H, MUL_M, DONE.
- Input transfer = i_valid & o_ready.
- o_ready = (state==IDLE) | (state==DONE & i_ready). It is combinational from state and i_ready.
- IDLE:
  - On input transfer, register all three pairs and clear the accumulator. Go to MUL_L.
  - Otherwise stay in IDLE.
- MUL_L: p = clmul(XL,YL). acc ← p ^ (p<<H). Go to MUL_H.
- MUL_H: p = clmul(XH,YH). acc ← acc ^ (p<<NB_DATA) ^ (p<<H). Go to MUL_M.
- MUL_M: p = clmul(XM,YM). acc ← acc ^ (p<<H). Go to DONE.
- DONE:
  - o_valid=1 and o_data=acc. Both are held stable while i_ready=0.
  - If i_ready=1 and input transfer: reload the operands, go to MUL_L (back-to-back).
  - If i_ready=1 and no transfer: go to IDLE.
- clmul is H×H → 2H-1 bits, zero-extended to 2*NB_DATA before shifting. All arithmetic is XOR; there are no carries.
- Inputs are ignored outside an input transfer. i_valid asserted in MUL_* states has no effect.
- Reset values: state=IDLE, o_valid=0, o_data=0, accumulator=0, operand registers=0.
  - o_ready is therefore 1 in the cycle reset deasserts.
- Reset asserted mid-operation: the in-flight product is discarded and o_valid drops asynchronously. No partial result is ever presented.

## Timing
- Input transfer at cycle t → MUL_L, MUL_H, MUL_M at t+1..t+3 → o_valid=1 from t+4.
- Latency: 4 cycles. Peak throughput: 1 product per 4 cycles with i_ready tied high.
- o_valid is registered. o_data is driven directly from the accumulator register.
- Backpressure: DONE is held indefinitely, and o_ready stays 0 until i_ready=1.

## Structure
- Shared header gf_2toN_koa_defs.vh holds:
  - State encodings (3-bit: IDLE=0, MUL_L=1, MUL_H=2, MUL_M=3, DONE=4).
  - Pair offsets within the bus (L=0, H=1, M=2).
- Sub-module gf_2toN_clmul: parameter NB_DATA (=H here). Purely combinational carry-less multiplier, instantiated once and fed by an operand mux selected by state.
- Top contains the FSM, operand registers, and accumulator.

## Test plan
- NB_DATA=8, i_data_bus=0x66C5A3 (a=0x53, b=0xCA), i_ready=1 → o_valid at t+4, o_data=0x3F7E, then return to IDLE.
- NB_DATA=128, all pairs zero except XL=YL=1 → o_data = 1 | (1<<64) ^ ... Concretely: L=1, H=0, M must equal (XL^XH)(YL^YH). Feed M pair X=1, Y=1 → o_data=1.
- Backpressure: NB_DATA=8, vector 1 with i_ready=0 for 10 cycles → o_valid and o_data=0x3F7E stable, o_ready=0 throughout. Release i_ready → one transfer.
- Back-to-back: i_valid held high with two vectors, i_ready=1 → second accepted in the DONE cycle of the first; results at t+4 and t+8, in order.
- Reset mid-operation: assert i_reset_n=0 during MUL_H → o_valid=0 immediately, state=IDLE. After release, o_ready=1 and no spurious output appears.
- Random: 1000 random NB_DATA=128 operand pairs split by a reference model, random i_valid/i_ready → every o_data matches the model's 256-bit carry-less product with bit 255=0.

Source files
------------

// File: rtl/gf_2ton_koa_seq_composer_pkg.sv
// Shared definitions for the sequential Karatsuba recombination stage:
// FSM state encoding and the position of each operand pair on the input bus.
package gf_2ton_koa_seq_composer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_L = 3'd1,
    MUL_H = 3'd2,
    MUL_M = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pair slot index on the splitter bus, in units of NB_DATA bits
  localparam int PAIR_L = 0;
  localparam int PAIR_H = 1;
  localparam int PAIR_M = 2;

endpackage

// File: rtl/gf_2ton_koa_seq_composer_clmul.sv
// Purely combinational carry-less (GF(2)[x]) multiplier, NB_DATA x NB_DATA
// operands producing the 2*NB_DATA-1 bit unreduced product.
module gf_2ton_koa_seq_composer_clmul #(
  parameter int NB_DATA = 64
) (
  input  logic [NB_DATA-1:0]   a,
  input  logic [NB_DATA-1:0]   b,
  output logic [2*NB_DATA-2:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < NB_DATA; i++) begin
      if (b[i]) p = p ^ ({{(NB_DATA-1){1'b0}}, a} << i);
    end
  end

endmodule

// File: rtl/gf_2ton_koa_seq_composer.sv
// Sequential Karatsuba recombination: one shared half-width clmul evaluates the
// low, high and middle pair products on consecutive cycles into an accumulator.
module gf_2ton_koa_seq_composer
  import gf_2ton_koa_seq_composer_pkg::*;
#(
  parameter int NB_DATA = 128
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [3*NB_DATA-1:0] i_data_bus,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [2*NB_DATA-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2:0]           dbg_state
);

  localparam int NB_HALF = NB_DATA / 2;

  state_t               state, state_nxt;
  logic [NB_DATA-1:0]   pair_l, pair_h, pair_m, sel_pair;
  logic [2*NB_DATA-1:0] acc, acc_nxt, p_ext;
  logic [NB_HALF-1:0]   mul_x, mul_y;
  logic [2*NB_HALF-2:0] prod;
  logic                 load;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid/data until it sees ready, and o_valid/o_data are
  // held stable in DONE until i_ready is seen.
  assign o_ready   = (state == IDLE) || ((state == DONE) && i_ready);
  assign load      = i_valid && o_ready;
  assign o_data    = acc;
  assign dbg_state = state;

  always_comb begin
    case (state)
      MUL_H:   sel_pair = pair_h;
      MUL_M:   sel_pair = pair_m;
      default: sel_pair = pair_l;
    endcase
  end

  assign mul_x = sel_pair[NB_HALF-1:0];
  assign mul_y = sel_pair[NB_DATA-1:NB_HALF];

  gf_2ton_koa_seq_composer_clmul #(
    .NB_DATA(NB_HALF)
  ) u_clmul (
    .a(mul_x),
    .b(mul_y),
    .p(prod)
  );

  assign p_ext = {{(2*NB_DATA-(2*NB_HALF-1)){1'b0}}, prod};

  // Middle term is (L ^ H ^ M) << H, folded in piecewise as each product appears
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = MUL_L;
          acc_nxt   = '0;
        end
      end
      MUL_L: begin
        acc_nxt   = p_ext ^ (p_ext << NB_HALF);
        state_nxt = MUL_H;
      end
      MUL_H: begin
        acc_nxt   = acc ^ (p_ext << NB_DATA) ^ (p_ext << NB_HALF);
        state_nxt = MUL_M;
      end
      MUL_M: begin
        acc_nxt   = acc ^ (p_ext << NB_HALF);
        state_nxt = DONE;
      end
      DONE: begin
        if (i_ready) begin
          if (load) begin
            state_nxt = MUL_L;
            acc_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      o_valid <= 1'b0;
      pair_l  <= '0;
      pair_h  <= '0;
      pair_m  <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      o_valid <= (state_nxt == DONE);
      if (load) begin
        pair_l <= i_data_bus[PAIR_L*NB_DATA +: NB_DATA];
        pair_h <= i_data_bus[PAIR_H*NB_DATA +: NB_DATA];
        pair_m <= i_data_bus[PAIR_M*NB_DATA +: NB_DATA];
      end
    end
  end

endmodule
